inst_loader: RTL

Upstream feeder of the fetch stage's instruction memory. Consumes the byte stream from the UART receiver, packs every four bytes (MSB first) into a 32-bit instruction, and issues one-cycle write strobes with an incrementing 7-bit word address into the instruction memory's write port. Loading stops on the HALT word or when memory is full. After that, the block grants the fetch stage permission to run.

---
 rtl/inst_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Packs UART bytes (MSB first) into 32-bit words and writes them to instruction memory, then
// enables fetch. Optional partial-word timeout is compiled in with LOADER_TIMEOUT_EN.
module inst_loader #(
  parameter int unsigned          NB_DATA        = 32,
  parameter int unsigned          NB_BYTE        = 8,
  parameter int unsigned          NB_ADDR        = 7,
  parameter logic [NB_DATA-1:0]   HALT_WORD      = 32'hFC000000,
  parameter int unsigned          TIMEOUT_CYCLES = 1000000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NB_BYTE-1:0] rx_data_i,
  input  logic               rx_done_i,
  output logic               en_write_o,
  output logic [NB_ADDR-1:0] addr_write_o,
  output logic [NB_DATA-1:0] data_o,
  output logic               fetch_enable_o,
  output logic               busy_o,
  output logic [NB_ADDR:0]   word_count_o,
  output logic               error_o
);

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RESET = NB_BYTE'(8'h52);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  state_e             state_q;
  logic [1:0]         byte_cnt_q;
  logic [NB_DATA-1:0] asm_q;
  logic [NB_DATA-1:0] data_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_ADDR:0]   word_count_q;
  logic               en_write_q;
  logic               fetch_enable_q;
  logic               busy_q;
  logic               error_q;
  logic [NB_DATA-1:0] asm_next;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
`endif

  assign asm_next = {asm_q[NB_DATA-NB_BYTE-1:0], rx_data_i};

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= StIdle;
      byte_cnt_q     <= 2'd0;
      asm_q          <= '0;
      data_q         <= '0;
      addr_q         <= '0;
      word_count_q   <= '0;
      en_write_q     <= 1'b0;
      fetch_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      en_write_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (rx_done_i && rx_data_i == CMD_LOAD) begin
            state_q        <= StRecv;
            byte_cnt_q     <= 2'd0;
            addr_q         <= '0;
            word_count_q   <= '0;
            error_q        <= 1'b0;
            fetch_enable_q <= 1'b0;
            busy_q         <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
            tmo_q          <= '0;
`endif
          end else if (rx_done_i && rx_data_i == CMD_RESET && state_q == StDone) begin
            state_q        <= StIdle;
            fetch_enable_q <= 1'b0;
          end
        end
        StRecv: begin
          if (rx_done_i) begin
            asm_q <= asm_next;
`ifdef LOADER_TIMEOUT_EN
            tmo_q <= '0;
`endif
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= 2'd0;
              data_q     <= asm_next;
              en_write_q <= 1'b1;
              state_q    <= StWrite;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
`ifdef LOADER_TIMEOUT_EN
          else if (byte_cnt_q != 2'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
              // Stalled partial word: drop it, keep already-written words intact.
              state_q    <= StIdle;
              byte_cnt_q <= 2'd0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
              tmo_q      <= '0;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
`endif
        end
        StWrite: begin
          word_count_q <= word_count_q + (NB_ADDR + 1)'(1);
          if (data_q == HALT_WORD || addr_q == '1) begin
            // Address saturates at the top word instead of wrapping.
            if (addr_q != '1) addr_q <= addr_q + NB_ADDR'(1);
            if (data_q != HALT_WORD) error_q <= 1'b1;
            state_q        <= StDone;
            fetch_enable_q <= 1'b1;
            busy_q         <= 1'b0;
          end else begin
            addr_q  <= addr_q + NB_ADDR'(1);
            state_q <= StRecv;
            // A strobe during the write cycle is the first byte of the next word.
            if (rx_done_i) begin
              asm_q      <= asm_next;
              byte_cnt_q <= 2'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_write_o     = en_write_q;
  assign addr_write_o   = addr_q;
  assign data_o         = data_q;
  assign fetch_enable_o = fetch_enable_q;
  assign busy_o         = busy_q;
  assign word_count_o   = word_count_q;
  assign error_o        = error_q;

endmodule
